// File: rtl/fpga_template_pkg.sv
// Shared types for the FPGA template: register-bank arbiter state, pending-write entry and port count.
package fpga_template_pkg;

  localparam int ARB_PORTS = 2;
  localparam int RB_ADDR_W = 8;
  localparam int RB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    OWN   = 2'd2
  } arb_state_t;

  // Default-width view of one parked write; the buffer itself follows its own parameters.
  typedef struct packed {
    logic                 valid;
    logic [RB_ADDR_W-1:0] addr;
    logic [RB_DATA_W-1:0] data;
  } rb_pend_t;

endpackage

// File: rtl/rb_arb_pend_buf.sv
// One-entry pending-write buffer with push/pop and a sticky overflow flag.
// A push arriving while the entry drains in the same cycle replaces it without overflow.
module rb_arb_pend_buf #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_full,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_overflow
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_overflow;
  logic              w_accept;

  assign w_accept = i_push && (!r_valid || i_pop);

  // A full entry keeps the older write; the newer one is dropped and flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_addr  <= i_addr;
        r_data  <= i_data;
      end else if (i_pop) begin
        r_valid <= 1'b0;
      end
      if (i_push && r_valid && !i_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_full     = r_valid;
  assign o_addr     = r_addr;
  assign o_data     = r_data;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/rb_arbiter.sv
// Round-robin arbiter sharing the register-bank port between the I2C (p0) and UART (p1) hosts.
// Writes from the non-owner are parked per port and replayed in FLUSH when that port is granted.
module rb_arbiter
  import fpga_template_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_reg_en,
  input  logic              p0_write_en,
  input  logic [ADDR_W-1:0] p0_address,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_overflow,
  input  logic              p1_reg_en,
  input  logic              p1_write_en,
  input  logic [ADDR_W-1:0] p1_address,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_overflow,
  output logic [1:0]        gnt,
  output logic [ADDR_W-1:0] rb_address,
  output logic [DATA_W-1:0] rb_wdata,
  output logic              rb_write_en,
  output logic              rb_reg_en,
  input  logic [DATA_W-1:0] rb_rdata
);

  localparam int               CNT_W   = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  arb_state_t           r_state, w_stateNext;
  logic                 r_owner, w_ownerNext;
  logic                 r_lastOwner, w_lastOwnerNext;
  logic [CNT_W-1:0]     r_holdCnt, w_holdCntNext;
  logic [ARB_PORTS-1:0] r_gnt;
  logic                 w_winner;

  logic [ARB_PORTS-1:0] w_regEn;
  logic [ARB_PORTS-1:0] w_writeEn;
  logic [ARB_PORTS-1:0] w_req;
  logic [ARB_PORTS-1:0] w_push;
  logic [ARB_PORTS-1:0] w_pop;
  logic [ARB_PORTS-1:0] w_pendValid;
  logic [ARB_PORTS-1:0] w_overflow;
  logic [ADDR_W-1:0]    w_addr     [ARB_PORTS];
  logic [DATA_W-1:0]    w_wdata    [ARB_PORTS];
  logic [ADDR_W-1:0]    w_pendAddr [ARB_PORTS];
  logic [DATA_W-1:0]    w_pendData [ARB_PORTS];
  logic                 w_ownActive;

  logic [ADDR_W-1:0]    r_rbAddr;
  logic [DATA_W-1:0]    r_rbWdata;
  logic                 r_rbWriteEn;
  logic                 r_rbRegEn;
  logic [DATA_W-1:0]    r_rdata [ARB_PORTS];

  assign w_regEn     = {p1_reg_en, p0_reg_en};
  assign w_writeEn   = {p1_write_en, p0_write_en};
  assign w_addr[0]   = p0_address;
  assign w_addr[1]   = p1_address;
  assign w_wdata[0]  = p0_wdata;
  assign w_wdata[1]  = p1_wdata;
  assign w_req       = w_regEn | w_pendValid;
  assign w_ownActive = (r_state == OWN);

  // Only the owner's writes in OWN go straight to the bank; every other write is parked.
  for (genvar g = 0; g < ARB_PORTS; g++) begin : g_pend
    assign w_push[g] = w_writeEn[g] && !(w_ownActive && (r_owner == 1'(g)));

    rb_arb_pend_buf #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
    ) u_pend (
      .clk       (clk),
      .reset     (reset),
      .i_push    (w_push[g]),
      .i_addr    (w_addr[g]),
      .i_data    (w_wdata[g]),
      .i_pop     (w_pop[g]),
      .o_full    (w_pendValid[g]),
      .o_addr    (w_pendAddr[g]),
      .o_data    (w_pendData[g]),
      .o_overflow(w_overflow[g])
    );
  end

  always_comb begin
    w_stateNext     = r_state;
    w_ownerNext     = r_owner;
    w_lastOwnerNext = r_lastOwner;
    w_holdCntNext   = r_holdCnt;
    w_winner        = r_owner;
    w_pop           = '0;

    case (r_state)
      IDLE: begin
        if (w_req != '0) begin
          // A tie goes to the port that did not win last time.
          if (w_req == 2'b11) begin
            w_winner = ~r_lastOwner;
          end else begin
            w_winner = w_req[1];
          end
          w_ownerNext     = w_winner;
          w_lastOwnerNext = w_winner;
          w_holdCntNext   = '0;
          w_stateNext     = w_pendValid[w_winner] ? FLUSH : OWN;
        end
      end
      FLUSH: begin
        w_pop[r_owner] = 1'b1;
        w_stateNext    = OWN;
      end
      OWN: begin
        if (r_holdCnt != CNT_MAX) begin
          w_holdCntNext = r_holdCnt + CNT_W'(1);
        end
        if ((!w_regEn[r_owner] && !w_writeEn[r_owner]) ||
            ((r_holdCnt == CNT_MAX) && w_req[~r_owner])) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_owner     <= 1'b0;
      r_lastOwner <= 1'b1;
      r_holdCnt   <= '0;
      r_gnt       <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_owner     <= w_ownerNext;
      r_lastOwner <= w_lastOwnerNext;
      r_holdCnt   <= w_holdCntNext;
      r_gnt       <= (w_stateNext == IDLE) ? 2'b00 : {w_ownerNext, ~w_ownerNext};
    end
  end

  // Bank outputs are loaded from the current state, so they trail it by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rbAddr    <= '0;
      r_rbWdata   <= '0;
      r_rbWriteEn <= 1'b0;
      r_rbRegEn   <= 1'b0;
    end else begin
      case (r_state)
        FLUSH: begin
          r_rbAddr    <= w_pendAddr[r_owner];
          r_rbWdata   <= w_pendData[r_owner];
          r_rbWriteEn <= 1'b1;
          r_rbRegEn   <= 1'b1;
        end
        OWN: begin
          r_rbAddr    <= w_addr[r_owner];
          r_rbWdata   <= w_wdata[r_owner];
          r_rbWriteEn <= w_writeEn[r_owner];
          r_rbRegEn   <= 1'b1;
        end
        default: begin
          r_rbWriteEn <= 1'b0;
          r_rbRegEn   <= 1'b0;
        end
      endcase
    end
  end

  // Read data is captured only on OWN cycles with no write on the bank port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata[0] <= '0;
      r_rdata[1] <= '0;
    end else if (w_ownActive && !r_rbWriteEn) begin
      r_rdata[r_owner] <= rb_rdata;
    end
  end

  assign gnt         = r_gnt;
  assign rb_address  = r_rbAddr;
  assign rb_wdata    = r_rbWdata;
  assign rb_write_en = r_rbWriteEn;
  assign rb_reg_en   = r_rbRegEn;
  assign p0_rdata    = r_rdata[0];
  assign p1_rdata    = r_rdata[1];
  assign p0_overflow = w_overflow[0];
  assign p1_overflow = w_overflow[1];

endmodule
